// File: rtl/fifo_multi_ported.sv
// In-order FIFO with PUSH_PORTS writers and POP_PORTS readers per cycle, arbitrary depth.
// Binary circular pointers wrap by conditional subtract; occupancy is held in an explicit counter.
module fifo_multi_ported #(
  parameter int DW         = 16,
  parameter int DEPTH      = 6,
  parameter int PUSH_PORTS = 2,
  parameter int POP_PORTS  = 2,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             valid_flush_i,
  input  logic [PUSH_PORTS-1:0]            push_i,
  input  logic [PUSH_PORTS-1:0][DW-1:0]    push_data_i,
  output logic [PUSH_PORTS-1:0]            ready_o,
  input  logic [POP_PORTS-1:0]             pop_i,
  output logic [POP_PORTS-1:0][DW-1:0]     pop_data_o,
  output logic [POP_PORTS-1:0]             valid_o,
  output logic [CW-1:0]                    count_o,
  output logic [CW-1:0]                    free_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = PW + 1;

  logic [DW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         free_w;
  logic [CW-1:0]         np, nq;
  logic [PUSH_PORTS-1:0] acc_push;
  logic [POP_PORTS-1:0]  acc_pop;
  logic [PW-1:0]         widx [PUSH_PORTS];
  logic [PW-1:0]         ridx [POP_PORTS];
  logic                  prev_push, prev_pop;

  // Both operands are below DEPTH, so one conditional subtract is a full modulo.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [AW-1:0] off);
    logic [AW-1:0] s;
    s = {1'b0, base} + off;
    if (s >= AW'(DEPTH)) s = s - AW'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign free_w  = CW'(DEPTH) - count_q;
  assign count_o = count_q;
  assign free_o  = free_w;

  always_comb begin
    ready_o   = '0;
    acc_push  = '0;
    np        = '0;
    prev_push = 1'b1;
    for (int i = 0; i < PUSH_PORTS; i++) begin
      ready_o[i]  = (free_w > CW'(i));
      acc_push[i] = push_i[i] & ready_o[i] & prev_push;
      prev_push   = acc_push[i];
      if (acc_push[i]) np = np + CW'(1);
      widx[i]     = wrap_add(tail_q, AW'(i));
    end
  end

  always_comb begin
    valid_o    = '0;
    acc_pop    = '0;
    nq         = '0;
    prev_pop   = 1'b1;
    pop_data_o = '0;
    for (int i = 0; i < POP_PORTS; i++) begin
      valid_o[i]    = (count_q > CW'(i));
      acc_pop[i]    = pop_i[i] & valid_o[i] & prev_pop;
      prev_pop      = acc_pop[i];
      if (acc_pop[i]) nq = nq + CW'(1);
      ridx[i]       = wrap_add(head_q, AW'(i));
      pop_data_o[i] = mem_q[ridx[i]];
    end
  end

  always_comb begin
    tail_d  = wrap_add(tail_q, AW'(np));
    head_d  = wrap_add(head_q, AW'(nq));
    count_d = count_q + np - nq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || valid_flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; flush and reset only move the pointers.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < PUSH_PORTS; i++) begin
      if (!rst_i && !valid_flush_i && acc_push[i]) mem_q[widx[i]] <= push_data_i[i];
    end
  end

endmodule

// File: doc/fifo_multi_ported.md
Name: fifo_multi_ported

Overview:
- Parametrised multi-ported FIFO for the core front-end and issue queues: W push ports and R pop ports per cycle, in-order, arbitrary (non-power-of-2) depth.
- Binary circular pointers with explicit occupancy count and free-slot outputs.
- Illegal pushes and pops are filtered internally, so the FIFO cannot overflow or underflow.
- Flush clears the FIFO in one cycle. Used between fetch/decode and rename/dispatch stages of differing widths.

Parameters:
- DW, 16, data width per entry.
- DEPTH, 6, number of entries; any value >= max(PUSH_PORTS, POP_PORTS) and >= 2.
- PUSH_PORTS, 2, push ports (W >= 1).
- POP_PORTS, 2, pop ports (R >= 1).
- CW, $clog2(DEPTH+1), derived, width of count/free outputs.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_flush  input  1  empty the FIFO at the next edge.
- push  input  W  per-port push request; port 0 is oldest.
- push_data  input  W x DW  push payloads; index i pairs with push[i].
- ready  output  W  ready[i]=1 iff free > i.
- pop  input  R  per-port pop request; port 0 is oldest.
- pop_data  output  R x DW  entry at head+i (mod DEPTH).
- valid  output  R  valid[i]=1 iff count > i.
- count  output  CW  current occupancy, 0..DEPTH.
- free  output  CW  DEPTH - count.

Behaviour:
- Reset (rst=1 at edge): head=0, tail=0, count=0. Outputs: valid all 0, ready[i]=1 for all i, count=0, free=DEPTH. pop_data is don't-care. Memory is not reset.
- Reset and flush have priority over push/pop in the same cycle. Flush produces the same pointer and count state as reset but leaves memory untouched.
- Accepted pushes: acc_push[0]=push[0]&ready[0]; acc_push[i]=push[i]&ready[i]&acc_push[i-1]. NP = number of set bits (a prefix). A gap in push (e.g. 2'b10) accepts nothing from above the gap.
- Accepted pops: same rule with pop/valid, giving acc_pop and NQ.
- ready/valid/count/free are functions of registered count only (Moore). A pop in the same cycle does not create room for a push: a full FIFO with simultaneous pop+push accepts the pop only.
- No bypass: data pushed in cycle n is first visible on pop_data/valid in cycle n+1. Push-to-pop latency is 1 cycle.
- Write: entry at (tail+i) mod DEPTH <= push_data[i] for each acc_push[i].
- Pointer update: tail <= (tail+NP) mod DEPTH; head <= (head+NQ) mod DEPTH. Wrap is done by conditional subtract of DEPTH; no power-of-2 masking.
- Count update: count <= count + NP - NQ. It never leaves 0..DEPTH by construction.
- pop_data[i] = mem[(head+i) mod DEPTH], combinational from registered head. It is meaningful only when valid[i].
- Simultaneous push and pop at count=0: pop is not accepted (valid=0), push is accepted, and count becomes NP.
- Requests on ports with ready/valid low are silently dropped. The producer must re-present them; no error flag.

Test Plan:
(DW=8, DEPTH=6, W=2, R=2 unless noted.)
1. Reset, then push=2'b11 with data {0x0B,0x0A} for 3 cycles -> count 2,4,6. At count=6: ready=00, free=0. pop_data[0]=0x0A, pop_data[1]=0x0B.
2. Full FIFO, push=11 and pop=11 in the same cycle -> only the pops are accepted. Next cycle: count=4, pop_data[0]=3rd pushed value.
3. Wrap: push 5 items, pop 4, then push 4 -> tail goes 5->3 via wrap, count=5. Popped order is exactly 5,6,7,8,9 across the wrap.
4. Partial/gapped requests: count=5, push=11 -> only port 0 accepted, count=6. Then push=2'b10 at count=4 -> nothing accepted, count stays 4.
5. Empty edge: count=1, pop=11 and push=01 -> NQ=1, NP=1, count stays 1. pop_data[0] next cycle = the new item. valid=01 throughout.
6. Flush and reset mid-stream: count=4 with valid_flush=1 and push=11 -> count=0, valid=00, ready=11; the pushes are ignored. Repeat with rst=1 -> same result. With W=3, R=1, DEPTH=3: push=111 after reset -> count=3, valid=1.
